fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction-fetch stage directly downstream of modulo_PC.
- Consumes the current PC and issues word reads to the synchronous instruction ROM.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Drives the PC-advance enable back to modulo_PC, so the PC moves only when a fetch is actually issued.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- ADDR_W, 10, instruction-memory word-address width.
- PTR_W, $clog2(DEPTH), FIFO pointer width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- pc_i  in  32  current PC from modulo_PC, byte address, word aligned.
- pc_advance_o  out  1  modulo_PC adds 4 at the next edge when high.
- imem_req_o  out  1  read strobe to instruction ROM.
- imem_addr_o  out  ADDR_W  word address = pc_i[ADDR_W+1:2].
- imem_rdata_i  in  32  ROM data, valid the cycle after imem_req_o.
- flush_i  in  1  branch/redirect: discard queue and in-flight read.
- inst_o  out  32  instruction at FIFO head.
- inst_pc_o  out  32  PC of that instruction.
- inst_valid_o  out  1  head entry valid.
- inst_ready_i  in  1  decode accepts head when valid and ready are both high.

Behaviour:
- Reset (reset==0, async):
  - count=0, pointers=0, inflight=0, drop=0, state=S_WAIT.
  - All outputs 0.
- FSM states:
  - S_WAIT: one idle cycle after reset release, no request; next state S_FETCH.
  - S_FETCH: normal operation.
  - S_DRAIN: one cycle after flush, no request, so the redirected PC settles; next state S_FETCH.
- Request rule, in S_FETCH: imem_req_o = !flush_i && (count + inflight - pop < DEPTH). pop is the current-cycle handshake, so a simultaneous pop frees a slot.
- pc_advance_o = imem_req_o; combinational, no other source.
- In-flight tracking:
  - A request latches inflight=1 and req_pc=pc_i.
  - In the following cycle, imem_rdata_i and req_pc are pushed into the FIFO unless drop==1.
  - At most one read is in flight.
- Read latency: request at edge N → data in FIFO after edge N+1 → inst_valid_o high during cycle N+1..N+2 window, i.e. the first cycle after the push.
- FIFO:
  - Circular buffer; read and write pointers wrap modulo DEPTH.
  - Count is PTR_W+1 bits.
  - Simultaneous push and pop when full or empty is legal; count is unchanged on push+pop.
  - Head outputs are combinational from the read pointer.
- Flush:
  - flush_i at edge E clears count and pointers and sets state=S_DRAIN.
  - An outstanding read gets drop=1; its data arriving in the next cycle is discarded, then drop clears.
  - A pop in the same cycle as the flush is ignored; decode must not rely on it.
  - No request is issued in the flush cycle or in S_DRAIN.
- Flush and reset together: reset wins.
- Reset asserted mid-operation: queue contents lost; outputs zero immediately (asynchronous).
- Full queue: imem_req_o=0, pc_advance_o=0, so the PC holds.
- Empty queue: inst_valid_o=0; inst_o and inst_pc_o are don't-care but must not be X after reset.

Optional Feature:
- FETCH_BYPASS_EN defined:
  - When the FIFO is empty and a non-dropped response arrives, inst_o/inst_pc_o come straight from imem_rdata_i/req_pc, with inst_valid_o=1 in that same cycle.
  - If inst_ready_i=1 the entry is not written into the FIFO.
  - Latency is 1 cycle from request.
- Undefined: every response goes through the FIFO; latency is 2 cycles from request.

Decomposition:
- Package fetch_pkg:
  - INSTR_W=32, PC_W=32.
  - typedef fetch_entry_t {instr, pc}.
  - enum fetch_state_t {S_WAIT, S_FETCH, S_DRAIN}.
- One sub-module, fetch_fifo: parameterised DEPTH, push/pop/flush, count/full/empty outputs, storing fetch_entry_t.
- fetch_queue holds the FSM, inflight/drop logic and request gating.

Test Plan:
- Reset, then pc_i=0x0 with PC incrementing on pc_advance_o, ROM word k = 0x1000+k, inst_ready_i=1 → stream 0x1000,0x1001,… with inst_pc_o 0x0,0x4,…; one instruction per cycle after fill; first valid 2 cycles after first request (1 with FETCH_BYPASS_EN).
- inst_ready_i=0 for 10 cycles, DEPTH=4 → exactly 4 entries buffered (PCs 0x0..0xC), then pc_advance_o=0 and pc_i held at 0x10; releasing ready drains in order with no loss or duplicate.
- flush_i pulsed while a read is in flight and 3 entries are queued → inst_valid_o=0 the next cycle; the dropped response never appears; no request in the S_DRAIN cycle; fetch resumes at the new pc_i=0x40 returning ROM word 0x1010.
- Full queue with inst_ready_i=1 in the same cycle → a request is issued that cycle (pop frees a slot); count stays 4.
- Reset asserted asynchronously mid-stream, between clock edges → all outputs 0 immediately; after release, one S_WAIT cycle with imem_req_o=0, then normal fetch.
- Pointer wrap: 3×DEPTH+1 instructions with random inst_ready_i → scoreboard shows in-order delivery and no corruption across wrap-around.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch queue: entry record and FSM states.
package fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        S_WAIT,
        S_FETCH,
        S_DRAIN
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetch entries with push/pop/flush and occupancy outputs.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  fetch_entry_t       wdata_i,
    output fetch_entry_t       rdata_o,
    output logic [PTR_W:0]     count_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam logic [PTR_W:0] FullCnt = (PTR_W+1)'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty_o = (count_q == '0);
        full_o  = (count_q == FullCnt);
        do_pop  = pop_i && !empty_o;
        // A pop in the same cycle frees the slot the push lands in.
        do_push = push_i && (!full_o || do_pop);
        rdata_o = mem_q[rptr_q];
        count_o = count_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= wptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: issues ROM reads from the PC, buffers responses, hands them to decode.
// Optional FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc_i,
    output logic              pc_advance_o,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [31:0]       imem_rdata_i,
    input  logic              flush_i,
    output logic [31:0]       inst_o,
    output logic [31:0]       inst_pc_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i
);

    fetch_state_t   state_q;
    logic           inflight_q;
    logic           drop_q;
    logic [31:0]    req_pc_q;

    fetch_entry_t   f_wdata;
    fetch_entry_t   f_head;
    logic [PTR_W:0] f_count;
    logic           f_full;
    logic           f_empty;
    logic           f_push;
    logic           f_pop;
    logic           rsp_valid;
    logic           pop;
    logic [PTR_W+1:0] occ;
    logic           unused_full;

    assign unused_full = f_full;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (f_push),
        .pop_i   (f_pop),
        .flush_i (flush_i),
        .wdata_i (f_wdata),
        .rdata_o (f_head),
        .count_o (f_count),
        .full_o  (f_full),
        .empty_o (f_empty)
    );

    always_comb begin
        f_wdata.instr = imem_rdata_i;
        f_wdata.pc    = req_pc_q;
        rsp_valid     = inflight_q && !drop_q && !flush_i;
        inst_o        = f_head.instr;
        inst_pc_o     = f_head.pc;
        inst_valid_o  = !f_empty;
        f_push        = rsp_valid;
`ifdef FETCH_BYPASS_EN
        if (f_empty && rsp_valid) begin
            inst_o       = imem_rdata_i;
            inst_pc_o    = req_pc_q;
            inst_valid_o = 1'b1;
            f_push       = !inst_ready_i;
        end
`endif
        pop   = inst_valid_o && inst_ready_i;
        f_pop = pop && !f_empty;
        // Slots committed: queued entries plus the read still in flight.
        occ = {1'b0, f_count} + (PTR_W+2)'(inflight_q) - (PTR_W+2)'(pop);
        imem_req_o   = (state_q == S_FETCH) && !flush_i && (occ < (PTR_W+2)'(DEPTH));
        pc_advance_o = imem_req_o;
        imem_addr_o  = imem_req_o ? pc_i[ADDR_W+1:2] : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_WAIT;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
            req_pc_q   <= '0;
        end else begin
            inflight_q <= imem_req_o;
            drop_q     <= flush_i && inflight_q;
            if (imem_req_o) begin
                req_pc_q <= pc_i;
            end
            case (state_q)
                S_WAIT:  state_q <= flush_i ? S_DRAIN : S_FETCH;
                S_FETCH: state_q <= flush_i ? S_DRAIN : S_FETCH;
                S_DRAIN: state_q <= flush_i ? S_DRAIN : S_FETCH;
                default: state_q <= S_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: PC/ROM models, vector table and scoreboard.
module tb_fetch_queue;
    import fetch_pkg::*;

`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif
    localparam int NVEC = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pc_advance;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        flush;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        ready;
    logic        pc_load;
    logic [31:0] pc_load_val;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pop = 0;

    fetch_entry_t sb[$];
    fetch_entry_t mon_e;

    typedef struct {
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_inst;
        logic [31:0] exp_pc;
    } vec_t;
    vec_t tbl [NVEC];

    always #5 clk = ~clk;

    fetch_queue dut (
        .clk          (clk),
        .reset        (reset),
        .pc_i         (pc),
        .pc_advance_o (pc_advance),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_rdata_i (imem_rdata),
        .flush_i      (flush),
        .inst_o       (inst),
        .inst_pc_o    (inst_pc),
        .inst_valid_o (inst_valid),
        .inst_ready_i (ready)
    );

    // modulo_PC stand-in with a redirect load.
    always @(posedge clk or negedge reset) begin
        if (!reset) pc <= 32'h0;
        else if (pc_load) pc <= pc_load_val;
        else if (pc_advance) pc <= pc + 32'd4;
    end

    // Synchronous ROM: word k holds 0x1000 + k.
    always @(posedge clk or negedge reset) begin
        if (!reset) imem_rdata <= 32'h0;
        else if (imem_req) imem_rdata <= 32'h1000 + {22'b0, imem_addr};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (imem_req) begin
                mon_e.instr = 32'h1000 + {22'b0, imem_addr};
                mon_e.pc    = pc;
                sb.push_back(mon_e);
            end
            if (inst_valid && ready && !flush) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_pop: got inst %h with no expected entry", inst);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_inst", inst, mon_e.instr);
                    chk("sb_pc", inst_pc, mon_e.pc);
                    n_pop++;
                end
            end
            if (flush) sb.delete();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b0;
        sb.delete();
        step();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        ready = 1'b0;
        pc_load = 1'b0;
        pc_load_val = 32'h0;

        for (int c = 0; c < NVEC; c++) begin
            tbl[c].ready     = 1'b1;
            tbl[c].exp_req   = (c >= 1);
            tbl[c].exp_addr  = (c >= 1) ? 32'(c - 1) : 32'h0;
            tbl[c].exp_valid = (c >= 1 + LAT);
            tbl[c].exp_inst  = 32'h1000 + 32'(c - 1 - LAT);
            tbl[c].exp_pc    = 32'(4 * (c - 1 - LAT));
        end

        #2;
        chk("rst_req", imem_req, 0);
        chk("rst_adv", pc_advance, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_pc", inst_pc, 0);

        // Streaming from reset with decode always ready.
        repeat (2) @(posedge clk);
        step();
        reset = 1'b1;
        ready = tbl[0].ready;
        for (int c = 0; c < NVEC; c++) begin
            if (c > 0) begin
                step();
                ready = tbl[c].ready;
            end
            @(negedge clk);
            chk($sformatf("vec%0d_req", c), imem_req, tbl[c].exp_req);
            chk($sformatf("vec%0d_adv", c), pc_advance, tbl[c].exp_req);
            chk($sformatf("vec%0d_valid", c), inst_valid, tbl[c].exp_valid);
            if (tbl[c].exp_req) chk($sformatf("vec%0d_addr", c), imem_addr, tbl[c].exp_addr);
            if (tbl[c].exp_valid) begin
                chk($sformatf("vec%0d_inst", c), inst, tbl[c].exp_inst);
                chk($sformatf("vec%0d_ipc", c), inst_pc, tbl[c].exp_pc);
            end
        end

        // Asynchronous reset between edges.
        @(posedge clk);
        #3;
        reset = 1'b0;
        sb.delete();
        #1;
        chk("arst_req", imem_req, 0);
        chk("arst_adv", pc_advance, 0);
        chk("arst_addr", imem_addr, 0);
        chk("arst_valid", inst_valid, 0);
        chk("arst_inst", inst, 0);
        chk("arst_pc", inst_pc, 0);
        step();
        reset = 1'b1;
        ready = 1'b0;
        @(negedge clk);
        chk("wait_req", imem_req, 0);
        @(negedge clk);
        chk("resume_req", imem_req, 1);
        chk("resume_addr", imem_addr, 0);

        // Back-pressure: queue fills to DEPTH and the PC holds.
        repeat (9) @(negedge clk);
        chk("full_req", imem_req, 0);
        chk("full_adv", pc_advance, 0);
        chk("full_pc_held", pc, 32'h10);
        chk("full_valid", inst_valid, 1);
        chk("full_head_pc", inst_pc, 32'h0);
        chk("full_head_inst", inst, 32'h1000);

        // Full queue with a pop in the same cycle still issues a fetch.
        step();
        ready = 1'b1;
        @(negedge clk);
        chk("fullpop_req", imem_req, 1);
        chk("fullpop_adv", pc_advance, 1);
        repeat (8) @(negedge clk);

        // Flush with three queued entries and one read in flight.
        do_reset();
        ready = 1'b0;
        repeat (5) step();
        flush = 1'b1;
        pc_load = 1'b1;
        pc_load_val = 32'h40;
        @(negedge clk);
        chk("flush_req", imem_req, 0);
        step();
        flush = 1'b0;
        pc_load = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        chk("drain_valid", inst_valid, 0);
        chk("drain_req", imem_req, 0);
        chk("drain_pc", pc, 32'h40);
        @(negedge clk);
        chk("redir_req", imem_req, 1);
        chk("redir_addr", imem_addr, 32'h10);
        begin
            int i;
            for (i = 0; i < 10; i++) begin
                if (inst_valid) break;
                @(negedge clk);
            end
            chk("redir_timeout", (i < 10), 1);
            chk("redir_inst", inst, 32'h1010);
            chk("redir_ipc", inst_pc, 32'h40);
        end

        // Random back-pressure across several pointer wraps.
        n_pop = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (n_pop >= 13) break;
        end
        chk("wrap_pops", (n_pop >= 13), 1);
        step();
        ready = 1'b1;
        repeat (6) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
